// File: rtl/pro_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pro_display_sequencer
// Debounced two-key operand-entry / ALU-execute / result sequencer that
// drives the type-select code and data word of the 4-digit 7-segment decoder.
// Rev    : 1.0  initial release
// ============================================================================
module pro_display_sequencer #(
    parameter int DEB_CYCLES  = 100000,
    parameter int DONE_HOLD   = 10000000,
    parameter int RUN_TIMEOUT = 1000
) (
    input  logic        clk_10M,
    input  logic        rst,
    input  logic        key_next_n,
    input  logic        key_back_n,
    input  logic [9:0]  sw,
    input  logic [15:0] alu_result,
    input  logic        alu_ovf,
    input  logic        alu_done,
    output logic [2:0]  ts,
    output logic [15:0] display_data,
    output logic [9:0]  cfg_src,
    output logic [9:0]  cfg_dst,
    output logic        alu_start,
    output logic        busy
);

    localparam int c_DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int c_HOLD_W = (DONE_HOLD   > 1) ? $clog2(DONE_HOLD)   : 1;
    localparam int c_TMO_W  = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_MAX  = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(DONE_HOLD - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_MAX  = c_TMO_W'(RUN_TIMEOUT - 1);

    localparam logic [2:0] c_TS_IDLE    = 3'b000;
    localparam logic [2:0] c_TS_DONE    = 3'b001;
    localparam logic [2:0] c_TS_OVF     = 3'b010;
    localparam logic [2:0] c_TS_SW_FULL = 3'b011;
    localparam logic [2:0] c_TS_SRC_ADR = 3'b100;
    localparam logic [2:0] c_TS_DST_ADR = 3'b101;
    localparam logic [2:0] c_TS_DATA_16 = 3'b110;
    localparam logic [2:0] c_TS_ADDR    = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SW     = 4'd1,
        S_SRC    = 4'd2,
        S_DST    = 4'd3,
        S_RUN    = 4'd4,
        S_DONE   = 4'd5,
        S_RESULT = 4'd6,
        S_ADDR   = 4'd7,
        S_OVF    = 4'd8
    } state_t;

    // ------------------------------------------------------------------
    // Key conditioning: index 0 = next, index 1 = back
    // ------------------------------------------------------------------
    logic [1:0] w_key_n;
    logic [1:0] w_press;

    assign w_key_n = {key_back_n, key_next_n};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_key
            logic               r_sync1;
            logic               r_sync2;
            logic               r_acc;
            logic               r_acc_d;
            logic               r_press;
            logic [c_DEB_W-1:0] r_cnt;

            always_ff @(posedge clk_10M or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_acc   <= 1'b1;
                    r_acc_d <= 1'b1;
                    r_press <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_key_n[g];
                    r_sync2 <= r_sync1;
                    r_acc_d <= r_acc;
                    r_press <= r_acc_d & ~r_acc;
                    // Any return to the accepted level restarts the stability count
                    if (r_sync2 == r_acc) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_MAX) begin
                        r_acc <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[g] = r_press;
        end
    endgenerate

    logic w_next;
    logic w_back;
    assign w_next = w_press[0];
    assign w_back = w_press[1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_back_pend;
    logic [15:0]         r_result;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;

    logic                w_latch_src;
    logic                w_launch;
    logic                w_capture;
    logic                w_back_any;
    logic                w_tmo;
    logic                w_hold_end;
    logic [2:0]          w_ts;
    logic [15:0]         w_disp;

    assign w_back_any = r_back_pend | w_back;
    assign w_tmo      = (r_tmo_cnt == c_TMO_MAX);
    assign w_hold_end = (r_hold_cnt == c_HOLD_MAX);

    always_ff @(posedge clk_10M or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch_src = 1'b0;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_ts        = c_TS_IDLE;
        w_disp      = display_data;

        unique case (r_state)
            S_IDLE: begin
                w_ts   = c_TS_IDLE;
                w_disp = 16'h0000;
                if (w_next && !w_back) w_state_nxt = S_SW;
            end
            S_SW: begin
                w_ts   = c_TS_SW_FULL;
                w_disp = {6'b0, sw};
                if (w_back)      w_state_nxt = S_IDLE;
                else if (w_next) w_state_nxt = S_SRC;
            end
            S_SRC: begin
                w_ts   = c_TS_SRC_ADR;
                w_disp = {6'b0, sw};
                if (w_back) begin
                    w_state_nxt = S_IDLE;
                end else if (w_next) begin
                    w_latch_src = 1'b1;
                    w_state_nxt = S_DST;
                end
            end
            S_DST: begin
                w_ts   = c_TS_DST_ADR;
                w_disp = {6'b0, sw};
                if (w_back) begin
                    w_state_nxt = S_IDLE;
                end else if (w_next) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A back request here is only remembered; the ALU cycle completes first
                w_ts = c_TS_DST_ADR;
                if (alu_done) begin
                    w_capture   = ~alu_ovf;
                    if (w_back_any)   w_state_nxt = S_IDLE;
                    else if (alu_ovf) w_state_nxt = S_OVF;
                    else              w_state_nxt = S_DONE;
                end else if (w_tmo) begin
                    w_state_nxt = w_back_any ? S_IDLE : S_OVF;
                end
            end
            S_DONE: begin
                w_ts = c_TS_DONE;
                if (w_back)                    w_state_nxt = S_IDLE;
                else if (w_next || w_hold_end) w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                w_ts   = c_TS_DATA_16;
                w_disp = r_result;
                if (w_back)      w_state_nxt = S_IDLE;
                else if (w_next) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_ts   = c_TS_ADDR;
                w_disp = {12'b0, sw[3:0]};
                if (w_back)      w_state_nxt = S_IDLE;
                else if (w_next) w_state_nxt = S_SW;
            end
            S_OVF: begin
                w_ts = c_TS_OVF;
                if (w_back || w_next) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_10M or posedge rst) begin
        if (rst) begin
            ts           <= c_TS_IDLE;
            display_data <= 16'h0000;
            cfg_src      <= 10'h000;
            cfg_dst      <= 10'h000;
            alu_start    <= 1'b0;
            busy         <= 1'b0;
            r_back_pend  <= 1'b0;
            r_result     <= 16'h0000;
            r_tmo_cnt    <= '0;
            r_hold_cnt   <= '0;
        end else begin
            ts           <= w_ts;
            display_data <= w_disp;
            alu_start    <= w_launch;
            busy         <= (r_state == S_RUN);
            if (w_latch_src) cfg_src  <= sw;
            if (w_launch)    cfg_dst  <= sw;
            if (w_capture)   r_result <= alu_result;
            r_back_pend <= (r_state == S_RUN) ? (r_back_pend | w_back) : 1'b0;
            // Counters sit at zero outside their state, so they start clean on entry
            r_tmo_cnt   <= (r_state == S_RUN)  ? r_tmo_cnt + 1'b1  : '0;
            r_hold_cnt  <= (r_state == S_DONE) ? r_hold_cnt + 1'b1 : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pro_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pro_display_sequencer
// Self-checking bench: reset, debounce timing, table-driven operation steps,
// multi-cycle corner sequences and a randomized run against a press-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pro_display_sequencer;

    localparam int DEB  = 8;
    localparam int HOLD = 200;
    localparam int TMO  = 1000;

    localparam int A_NEXT = 0;
    localparam int A_BACK = 1;
    localparam int A_BOTH = 2;
    localparam int A_DONE = 3;

    localparam int P_IDLE = 0, P_SW = 1, P_SRC = 2, P_DST = 3, P_RUN = 4,
                   P_DONE = 5, P_RESULT = 6, P_ADDR = 7, P_OVF = 8;

    logic        clk_10M = 1'b0;
    logic        rst;
    logic        key_next_n;
    logic        key_back_n;
    logic [9:0]  sw;
    logic [15:0] alu_result;
    logic        alu_ovf;
    logic        alu_done;
    logic [2:0]  ts;
    logic [15:0] display_data;
    logic [9:0]  cfg_src;
    logic [9:0]  cfg_dst;
    logic        alu_start;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    pro_display_sequencer #(
        .DEB_CYCLES (DEB),
        .DONE_HOLD  (HOLD),
        .RUN_TIMEOUT(TMO)
    ) dut (
        .clk_10M     (clk_10M),
        .rst         (rst),
        .key_next_n  (key_next_n),
        .key_back_n  (key_back_n),
        .sw          (sw),
        .alu_result  (alu_result),
        .alu_ovf     (alu_ovf),
        .alu_done    (alu_done),
        .ts          (ts),
        .display_data(display_data),
        .cfg_src     (cfg_src),
        .cfg_dst     (cfg_dst),
        .alu_start   (alu_start),
        .busy        (busy)
    );

    always #50 clk_10M = ~clk_10M;

    typedef struct {
        int          act;
        logic [9:0]  sw;
        logic [15:0] res;
        logic        ovf;
        logic [2:0]  exp_ts;
        logic [15:0] exp_disp;
        logic [9:0]  exp_src;
        logic [9:0]  exp_dst;
        logic        exp_busy;
    } step_t;

    step_t tbl [24];

    // press-level reference model
    int          m_ph;
    logic [9:0]  m_src, m_dst;
    logic [15:0] m_res, m_disp;
    bit          m_pend;
    int          m_runp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_10M);
    endtask

    task automatic press(input bit nxt, input bit bck);
        key_next_n = ~nxt;
        key_back_n = ~bck;
        tick(DEB + 6);
        key_next_n = 1'b1;
        key_back_n = 1'b1;
        tick(DEB + 6);
    endtask

    task automatic done_pulse(input logic [15:0] r, input logic o);
        alu_result = r;
        alu_ovf    = o;
        alu_done   = 1'b1;
        tick(1);
        alu_done   = 1'b0;
        tick(3);
    endtask

    function automatic logic [2:0] ts_of(input int ph);
        case (ph)
            P_SW:     return 3'b011;
            P_SRC:    return 3'b100;
            P_DST:    return 3'b101;
            P_RUN:    return 3'b101;
            P_DONE:   return 3'b001;
            P_RESULT: return 3'b110;
            P_ADDR:   return 3'b111;
            P_OVF:    return 3'b010;
            default:  return 3'b000;
        endcase
    endfunction

    task automatic m_refresh();
        case (m_ph)
            P_IDLE:              m_disp = 16'h0000;
            P_SW, P_SRC, P_DST:  m_disp = {6'b0, sw};
            P_RESULT:            m_disp = m_res;
            P_ADDR:              m_disp = {12'b0, sw[3:0]};
            default:             m_disp = m_disp;
        endcase
    endtask

    task automatic m_next();
        case (m_ph)
            P_IDLE:   m_ph = P_SW;
            P_SW:     m_ph = P_SRC;
            P_SRC:    begin m_src = sw; m_ph = P_DST; end
            P_DST:    begin m_dst = sw; m_ph = P_RUN; m_pend = 0; m_runp = 0; end
            P_DONE:   m_ph = P_RESULT;
            P_RESULT: m_ph = P_ADDR;
            P_ADDR:   m_ph = P_SW;
            P_OVF:    m_ph = P_IDLE;
            default:  m_ph = m_ph;
        endcase
    endtask

    initial begin
        #8ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t_busy, t_ovf, starts, n_done_ts, r;
        bit seen;
        logic [15:0] rres;
        logic        rov;

        tbl[0]  = '{A_NEXT, 10'h155, 16'h0000, 1'b0, 3'b011, 16'h0155, 10'h000, 10'h000, 1'b0};
        tbl[1]  = '{A_NEXT, 10'h2C5, 16'h0000, 1'b0, 3'b100, 16'h02C5, 10'h000, 10'h000, 1'b0};
        tbl[2]  = '{A_NEXT, 10'h2C5, 16'h0000, 1'b0, 3'b101, 16'h02C5, 10'h2C5, 10'h000, 1'b0};
        tbl[3]  = '{A_NEXT, 10'h013, 16'h0000, 1'b0, 3'b101, 16'h0013, 10'h2C5, 10'h013, 1'b1};
        tbl[4]  = '{A_DONE, 10'h013, 16'h3039, 1'b0, 3'b001, 16'h0013, 10'h2C5, 10'h013, 1'b0};
        tbl[5]  = '{A_NEXT, 10'h013, 16'h0000, 1'b0, 3'b110, 16'h3039, 10'h2C5, 10'h013, 1'b0};
        tbl[6]  = '{A_NEXT, 10'h3A7, 16'h0000, 1'b0, 3'b111, 16'h0007, 10'h2C5, 10'h013, 1'b0};
        tbl[7]  = '{A_NEXT, 10'h0AA, 16'h0000, 1'b0, 3'b011, 16'h00AA, 10'h2C5, 10'h013, 1'b0};
        tbl[8]  = '{A_BOTH, 10'h0AA, 16'h0000, 1'b0, 3'b000, 16'h0000, 10'h2C5, 10'h013, 1'b0};
        tbl[9]  = '{A_NEXT, 10'h1F0, 16'h0000, 1'b0, 3'b011, 16'h01F0, 10'h2C5, 10'h013, 1'b0};
        tbl[10] = '{A_NEXT, 10'h1F0, 16'h0000, 1'b0, 3'b100, 16'h01F0, 10'h2C5, 10'h013, 1'b0};
        tbl[11] = '{A_BOTH, 10'h3FF, 16'h0000, 1'b0, 3'b000, 16'h0000, 10'h2C5, 10'h013, 1'b0};
        tbl[12] = '{A_NEXT, 10'h001, 16'h0000, 1'b0, 3'b011, 16'h0001, 10'h2C5, 10'h013, 1'b0};
        tbl[13] = '{A_NEXT, 10'h001, 16'h0000, 1'b0, 3'b100, 16'h0001, 10'h2C5, 10'h013, 1'b0};
        tbl[14] = '{A_NEXT, 10'h002, 16'h0000, 1'b0, 3'b101, 16'h0002, 10'h002, 10'h013, 1'b0};
        tbl[15] = '{A_NEXT, 10'h004, 16'h0000, 1'b0, 3'b101, 16'h0004, 10'h002, 10'h004, 1'b1};
        tbl[16] = '{A_DONE, 10'h004, 16'hFFFF, 1'b1, 3'b010, 16'h0004, 10'h002, 10'h004, 1'b0};
        tbl[17] = '{A_NEXT, 10'h004, 16'h0000, 1'b0, 3'b000, 16'h0000, 10'h002, 10'h004, 1'b0};
        tbl[18] = '{A_NEXT, 10'h010, 16'h0000, 1'b0, 3'b011, 16'h0010, 10'h002, 10'h004, 1'b0};
        tbl[19] = '{A_NEXT, 10'h010, 16'h0000, 1'b0, 3'b100, 16'h0010, 10'h002, 10'h004, 1'b0};
        tbl[20] = '{A_NEXT, 10'h020, 16'h0000, 1'b0, 3'b101, 16'h0020, 10'h020, 10'h004, 1'b0};
        tbl[21] = '{A_NEXT, 10'h030, 16'h0000, 1'b0, 3'b101, 16'h0030, 10'h020, 10'h030, 1'b1};
        tbl[22] = '{A_BACK, 10'h030, 16'h0000, 1'b0, 3'b101, 16'h0030, 10'h020, 10'h030, 1'b1};
        tbl[23] = '{A_DONE, 10'h030, 16'h002A, 1'b0, 3'b000, 16'h0000, 10'h020, 10'h030, 1'b0};

        rst = 1'b1; key_next_n = 1'b1; key_back_n = 1'b1; sw = '0;
        alu_result = '0; alu_ovf = 1'b0; alu_done = 1'b0;
        tick(3);
        check("rst_ts", ts, 3'b000);
        check("rst_disp", display_data, 16'h0000);
        check("rst_cfg_src", cfg_src, 10'h000);
        check("rst_cfg_dst", cfg_dst, 10'h000);
        check("rst_alu_start", alu_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(3);

        // Debounce: three 2-cycle bounces, then a 20-cycle hold
        for (int b = 0; b < 3; b++) begin
            key_next_n = 1'b0; tick(2);
            key_next_n = 1'b1; tick(2);
        end
        check("deb_bounce_ignored", ts, 3'b000);
        key_next_n = 1'b0;
        // press pulse DEB+3 edges after the stable low, FSM +1, registered ts +1
        tick(DEB + 4);
        check("deb_ts_before", ts, 3'b000);
        tick(1);
        check("deb_ts_after", ts, 3'b011);
        tick(20 - (DEB + 5));
        key_next_n = 1'b1;
        tick(DEB + 6);
        check("deb_single_pulse", ts, 3'b011);
        press(0, 1);
        check("back_to_idle", ts, 3'b000);

        // Table-driven operation steps
        for (int i = 0; i < 24; i++) begin
            sw = tbl[i].sw;
            tick(1);
            case (tbl[i].act)
                A_NEXT:  press(1, 0);
                A_BACK:  press(0, 1);
                A_BOTH:  press(1, 1);
                default: done_pulse(tbl[i].res, tbl[i].ovf);
            endcase
            check($sformatf("tbl%0d_ts", i), ts, tbl[i].exp_ts);
            check($sformatf("tbl%0d_disp", i), display_data, tbl[i].exp_disp);
            check($sformatf("tbl%0d_src", i), cfg_src, tbl[i].exp_src);
            check($sformatf("tbl%0d_dst", i), cfg_dst, tbl[i].exp_dst);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
        end
        check("back_run_result", dut.r_result, 16'd42);

        // Full operation with cycle-level start/done/hold observation
        sw = 10'h2C5;
        press(1, 0); press(1, 0); press(1, 0);
        sw = 10'h013;
        key_next_n = 1'b0;
        t0 = -1; starts = 0; n_done_ts = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_10M);
            alu_done = 1'b0;
            if (c == DEB + 6) key_next_n = 1'b1;
            if (alu_start) begin
                starts++;
                if (t0 < 0) t0 = c;
            end
            if (ts == 3'b001) n_done_ts++;
            if (t0 >= 0 && c == t0 + 5) begin
                alu_result = 16'd12345; alu_ovf = 1'b0; alu_done = 1'b1;
            end
        end
        alu_done = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3 * HOLD; c++) begin
            @(negedge clk_10M);
            if (alu_start) starts++;
            if (ts == 3'b110) begin seen = 1'b1; break; end
            if (ts == 3'b001) n_done_ts++;
        end
        check("op_cfg_src", cfg_src, 10'h2C5);
        check("op_cfg_dst", cfg_dst, 10'h013);
        check("op_start_cycles", starts, 1);
        check("op_done_hold", n_done_ts, HOLD);
        check("op_result_seen", seen, 1'b1);
        check("op_result_disp", display_data, 16'd12345);
        press(0, 1);
        check("op_back_idle", ts, 3'b000);

        // Timeout: the ALU takes start at the edge after alu_start rises;
        // ts/busy reflect the timeout TMO cycles after that edge
        sw = 10'h111;
        press(1, 0); press(1, 0); press(1, 0);
        key_next_n = 1'b0;
        t0 = -1; t_busy = -1; t_ovf = -1;
        for (int c = 0; c < TMO + 100; c++) begin
            @(negedge clk_10M);
            if (c == DEB + 6) key_next_n = 1'b1;
            if (t0 < 0 && alu_start) t0 = c;
            if (t0 >= 0 && c > t0 && t_busy < 0 && !busy) t_busy = c;
            if (t_ovf < 0 && ts == 3'b010) t_ovf = c;
            if (t_ovf >= 0 && t_busy >= 0) break;
        end
        check("tmo_ovf_cycle", t_ovf - t0, TMO + 1);
        check("tmo_busy_fall", t_busy - t0, TMO + 1);
        press(1, 0);
        check("tmo_next_idle", ts, 3'b000);

        // Async reset while alu_start is high
        sw = 10'h0F0;
        press(1, 0); press(1, 0); press(1, 0);
        key_next_n = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_10M);
            if (alu_start) begin seen = 1'b1; break; end
        end
        check("rstrun_start_seen", seen, 1'b1);
        check("rstrun_cfg_before", cfg_src, 10'h0F0);
        #5 rst = 1'b1;
        #1;
        check("rstrun_ts", ts, 3'b000);
        check("rstrun_alu_start", alu_start, 1'b0);
        check("rstrun_busy", busy, 1'b0);
        check("rstrun_cfg_src", cfg_src, 10'h000);
        check("rstrun_cfg_dst", cfg_dst, 10'h000);
        key_next_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        done_pulse(16'hBEEF, 1'b0);
        check("stray_done_ts", ts, 3'b000);
        check("stray_done_busy", busy, 1'b0);
        check("stray_done_result", dut.r_result, 16'h0000);

        // Randomized press-level run against the reference model
        m_ph = P_IDLE; m_src = '0; m_dst = '0; m_res = '0; m_disp = '0;
        m_pend = 0; m_runp = 0;
        for (int it = 0; it < 80; it++) begin
            sw = 10'($urandom);
            tick(1);
            m_refresh();
            if (m_ph == P_RUN) begin
                r = $urandom_range(0, 3);
                if (m_runp >= 2) r = 3;
                if (r == 0) begin
                    press(0, 1); m_pend = 1; m_runp++;
                end else if (r == 1) begin
                    press(1, 0); m_runp++;
                end else begin
                    rres = 16'($urandom);
                    rov  = ($urandom_range(0, 3) == 0);
                    done_pulse(rres, rov);
                    if (!rov) m_res = rres;
                    m_ph   = m_pend ? P_IDLE : (rov ? P_OVF : P_DONE);
                    m_pend = 0;
                end
            end else begin
                r = $urandom_range(0, 5);
                if (r == 5 && m_ph == P_DONE) r = 2;
                case (r)
                    0: begin press(0, 1); m_ph = P_IDLE; end
                    1: begin press(1, 1); m_ph = P_IDLE; end
                    5: done_pulse(16'($urandom), 1'($urandom));
                    default: begin press(1, 0); m_next(); end
                endcase
            end
            m_refresh();
            check($sformatf("rnd%0d_ts", it), ts, ts_of(m_ph));
            check($sformatf("rnd%0d_disp", it), display_data, m_disp);
            check($sformatf("rnd%0d_src", it), cfg_src, m_src);
            check($sformatf("rnd%0d_dst", it), cfg_dst, m_dst);
            check($sformatf("rnd%0d_busy", it), busy, (m_ph == P_RUN));
            check($sformatf("rnd%0d_start", it), alu_start, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
